// File: rtl/stepper_phase_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// Module      : stepper_pkg
// Description : Shared types and coil pattern tables for the stepper phase
//               sequencer. HALF_STEP_EN selects the 8-entry half-step table.
// Revision    : 1.0 - initial release
// =============================================================================
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DWELL = 2'd2
    } state_t;

`ifdef HALF_STEP_EN
    localparam int PHASE_N = 8;
    localparam int PHASE_W = 3;
    // Entry i sits at bits [4*i +: 4]
    localparam logic [PHASE_N*4-1:0] COIL_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };
`else
    localparam int PHASE_N = 4;
    localparam int PHASE_W = 2;
    localparam logic [PHASE_N*4-1:0] COIL_TABLE = {
        4'b1000, 4'b0100, 4'b0010, 4'b0001
    };
`endif

    function automatic logic [3:0] coil_of(input logic [PHASE_W-1:0] phase);
        return COIL_TABLE[{phase, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_phase_sequencer_step_tick_gen.sv
`default_nettype none
// =============================================================================
// Module      : step_tick_gen
// Description : Step-rate divider; counts 0..STEP_DIV-1 while enabled and
//               emits a one-cycle tick on the terminal count.
// Revision    : 1.0 - initial release
// =============================================================================
module step_tick_gen #(
    parameter int STEP_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int                 c_div_w = $clog2(STEP_DIV);
    localparam logic [c_div_w-1:0] c_last  = c_div_w'(STEP_DIV - 1);

    logic [c_div_w-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == c_last) ? '0 : r_count + c_div_w'(1);
        end
    end

    assign o_tick = i_enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/stepper_phase_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : stepper_phase_sequencer
// Description : Commanded N-step coil sequencer with abort; phase index is kept
//               across moves. HALF_STEP_EN selects half-step drive.
// Revision    : 1.0 - initial release
// =============================================================================
module stepper_phase_sequencer
    import stepper_pkg::*;
#(
    parameter int STEP_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] step_count,
    input  logic             stop,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    state_t             r_state, w_state_nxt;
    logic [PHASE_W-1:0] r_phase, w_phase_nxt, w_phase_step;
    logic               r_dir,   w_dir_nxt;
    logic [CNT_W-1:0]   r_steps, w_steps_nxt;
    logic [3:0]         r_coil,  w_coil_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               r_done,  w_done_nxt;
    logic               w_tick;

    // Divider is held cleared in IDLE so every move starts a fresh dwell period
    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (r_state == IDLE),
        .i_enable (r_state != IDLE),
        .o_tick   (w_tick)
    );

    // Power-of-two phase count: natural wrap gives the modulo
    assign w_phase_step = r_dir ? r_phase + PHASE_W'(1) : r_phase - PHASE_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_dir_nxt   = r_dir;
        w_steps_nxt = r_steps;
        w_coil_nxt  = r_coil;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_coil_nxt = 4'b0000;
                w_busy_nxt = 1'b0;
                if (start && !stop) begin
                    if (step_count != '0) begin
                        w_state_nxt = RUN;
                        w_dir_nxt   = dir;
                        w_steps_nxt = step_count;
                        w_coil_nxt  = coil_of(r_phase);
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_steps_nxt = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_coil_nxt  = 4'b0000;
                    w_busy_nxt  = 1'b0;
                end else if (w_tick) begin
                    w_phase_nxt = w_phase_step;
                    w_coil_nxt  = coil_of(w_phase_step);
                    w_steps_nxt = r_steps - CNT_W'(1);
                    if (r_steps == CNT_W'(1)) begin
                        w_state_nxt = DWELL;
                    end
                end
            end
            DWELL: begin
                if (stop || w_tick) begin
                    w_state_nxt = IDLE;
                    w_coil_nxt  = 4'b0000;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = !stop;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_coil_nxt  = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_dir   <= 1'b0;
            r_steps <= '0;
            r_coil  <= 4'b0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_dir   <= w_dir_nxt;
            r_steps <= w_steps_nxt;
            r_coil  <= w_coil_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign coil       = r_coil;
    assign busy       = r_busy;
    assign done       = r_done;
    assign steps_left = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_stepper_phase_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : tb_stepper_phase_sequencer
// Description : Self-checking bench for stepper_phase_sequencer (STEP_DIV=4);
//               honours HALF_STEP_EN for the expected coil table.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_stepper_phase_sequencer;

    localparam int DIV   = 4;
    localparam int CNT_W = 16;
`ifdef HALF_STEP_EN
    localparam int PN = 8;
`else
    localparam int PN = 4;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             dir   = 1'b0;
    logic [CNT_W-1:0] step_count = '0;
    logic             stop  = 1'b0;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    int checks   = 0;
    int failures = 0;
    int cur_t    = 0;
    int m_phase  = 0;
    int m_steps  = 0;

    stepper_phase_sequencer #(
        .STEP_DIV (DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dir        (dir),
        .step_count (step_count),
        .stop       (stop),
        .coil       (coil),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] pat(input int p);
`ifdef HALF_STEP_EN
        logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0100, 4'b1100, 4'b1000, 4'b1001};
        return tbl[p];
`else
        return 4'(1 << p);
`endif
    endfunction

    function automatic int wrap(input int p);
        return ((p % PN) + PN) % PN;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=0x%0h expected=0x%0h", tag, cur_t, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] c, input logic b,
                             input logic d, input int s);
        check({tag, ".coil"}, 32'(coil), 32'(c));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".steps_left"}, 32'(steps_left), 32'(s));
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Move of n steps; stop_at>0 raises stop during cycle stop_at after acceptance.
    // Junk start/dir/step_count are thrown at the DUT while it is busy.
    task automatic do_move(input logic d, input int n, input int stop_at);
        int p0;
        int k;
        int last;
        int sgn;
        p0   = m_phase;
        sgn  = d ? 1 : -1;
        last = (n + 1) * DIV;
        start = 1'b1; dir = d; step_count = CNT_W'(n);
        next_cycle();
        start = 1'b0;
        if (n == 0) begin
            cur_t = 1;
            check_all("zero_cnt", 4'b0000, 1'b0, 1'b1, 0);
            m_steps = 0;
            next_cycle();
            cur_t = 2;
            check_all("zero_cnt_after", 4'b0000, 1'b0, 1'b0, 0);
            return;
        end
        for (int t = 1; t <= last + 1; t++) begin
            cur_t = t;
            if (stop_at != 0 && t == stop_at + 1) begin
                k = (stop_at - 1) / DIV;
                if (k > n) k = n;
                check_all("abort", 4'b0000, 1'b0, 1'b0, n - k);
                m_phase = wrap(p0 + sgn * k);
                m_steps = n - k;
                break;
            end
            if (t == last + 1) begin
                check_all("done", 4'b0000, 1'b0, 1'b1, 0);
                m_phase = wrap(p0 + sgn * n);
                m_steps = 0;
                break;
            end
            k = (t - 1) / DIV;
            if (k > n) k = n;
            check_all("move", pat(wrap(p0 + sgn * k)), 1'b1, 1'b0, n - k);
            start      = ($urandom_range(0, 3) == 0);
            dir        = 1'($urandom_range(0, 1));
            step_count = CNT_W'($urandom_range(0, 7));
            if (t == stop_at) stop = 1'b1;
            next_cycle();
            stop  = 1'b0;
            start = 1'b0;
        end
        next_cycle();
        cur_t++;
        check_all("post_move", 4'b0000, 1'b0, 1'b0, m_steps);
    endtask

    initial begin
        int n;
        int s;
        logic d;

        repeat (3) next_cycle();
        reset = 1'b0;
        cur_t = 0;
        check_all("reset", 4'b0000, 1'b0, 1'b0, 0);

        do_move(1'b1, 3, 0);
        do_move(1'b0, 2, 0);
        do_move(1'b1, 2, 0);
        do_move(1'b1, 1, 0);
        do_move(1'b0, 1, 0);
        do_move(1'b1, 5, 7);
        do_move(1'b0, 0, 0);

        // stop and start in the same idle cycle: request dropped
        start = 1'b1; stop = 1'b1; dir = 1'b1; step_count = CNT_W'(3);
        next_cycle();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cur_t = i + 1;
            check_all("start_stop", 4'b0000, 1'b0, 1'b0, m_steps);
            next_cycle();
        end
        do_move(1'b0, 1, 0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 5);
            d = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (n + 1) * DIV) : 0;
            do_move(d, n, (n == 0) ? 0 : s);
        end

        // reset mid-move: outputs clear, phase back to 0, no done afterwards
        start = 1'b1; dir = 1'b1; step_count = CNT_W'(4);
        next_cycle();
        start = 1'b0;
        repeat (6) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        cur_t = 0;
        check_all("mid_reset", 4'b0000, 1'b0, 1'b0, 0);
        m_phase = 0;
        m_steps = 0;
        next_cycle();
        check_all("mid_reset_after", 4'b0000, 1'b0, 1'b0, 0);

        do_move(1'b1, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
